// File: rtl/ram_arbiter_if.sv
// Bus bundle between the CPU requester, the video fetch path, the shared RAM and ram_arbiter.
// The arbiter takes the slave modport; requesters and the RAM model sit on the master side.
interface ram_arbiter_if #(
   parameter int A = 12,
   parameter int D = 8
);
   logic         cpu_req;
   logic         cpu_rw;
   logic [A-1:0] cpu_addr;
   logic [D-1:0] cpu_wdata;
   logic         cpu_gnt;
   logic         cpu_rvalid;
   logic [D-1:0] cpu_rdata;

   logic         vid_req;
   logic [A-1:0] vid_addr;
   logic         vid_urgent;
   logic         vid_gnt;
   logic         vid_rvalid;
   logic [D-1:0] vid_rdata;

   logic         ram_cs;
   logic         ram_rw;
   logic [A-1:0] ram_addr;
   logic [D-1:0] ram_wdata;
   logic [D-1:0] ram_rdata;

   modport slave (
      input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
      input  vid_req, vid_addr, vid_urgent,
      input  ram_rdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      output vid_gnt, vid_rvalid, vid_rdata,
      output ram_cs, ram_rw, ram_addr, ram_wdata
   );

   modport master (
      output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
      output vid_req, vid_addr, vid_urgent,
      output ram_rdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      input  vid_gnt, vid_rvalid, vid_rdata,
      input  ram_cs, ram_rw, ram_addr, ram_wdata
   );
endinterface

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between CPU and video fetch: one access per clk, CPU anti-starvation.
// Optional ARB_STATS_EN adds saturating conflict / forced-grant counters with stat_clr.
module ram_arbiter #(
   parameter int A        = 12,
   parameter int D        = 8,
   parameter int MAX_WAIT = 15,
   parameter int STAT_W   = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   ram_arbiter_if.slave bus
`ifdef ARB_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [STAT_W-1:0] stat_conflicts,
   output logic [STAT_W-1:0] stat_forced
`endif
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic {OWN_CPU = 1'b0, OWN_VID = 1'b1} owner_t;
   typedef enum logic [1:0] {MODE_FORCE_CPU, MODE_VID_PRI, MODE_RR} mode_t;

   if (MAX_WAIT < 1) begin : g_bad_max_wait
      $error("MAX_WAIT must be >= 1");
   end
   if (STAT_W < 1) begin : g_bad_stat_w
      $error("STAT_W must be >= 1");
   end

   owner_t            last_q;
   logic [WAIT_W-1:0] cpu_wait_q;
   logic              cpu_rvalid_p1;
   logic              vid_rvalid_p1;
   mode_t             mode;
   logic              force_cpu;
   logic              cpu_win;
   logic              vid_win;

   function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
      if (v >= WAIT_W'(MAX_WAIT)) return WAIT_W'(MAX_WAIT);
      return v + 1'b1;
   endfunction

   // Arbitration: mode and winner decided from registered state and current requests
   always_comb begin
      mode      = MODE_RR;
      cpu_win   = 1'b0;
      vid_win   = 1'b0;
      force_cpu = bus.cpu_req && (cpu_wait_q == WAIT_W'(MAX_WAIT));
      if (force_cpu)           mode = MODE_FORCE_CPU;
      else if (bus.vid_urgent) mode = MODE_VID_PRI;
      case (mode)
         MODE_FORCE_CPU: cpu_win = 1'b1;
         MODE_VID_PRI: begin
            vid_win = bus.vid_req;
            cpu_win = !bus.vid_req && bus.cpu_req;
         end
         default: begin
            if (bus.cpu_req && bus.vid_req) begin
               cpu_win = (last_q == OWN_VID);
               vid_win = (last_q == OWN_CPU);
            end else begin
               cpu_win = bus.cpu_req;
               vid_win = bus.vid_req;
            end
         end
      endcase
      // Nothing may reach the RAM while reset is held, whatever the requesters do
      if (!reset_n) begin
         cpu_win = 1'b0;
         vid_win = 1'b0;
      end
   end

   always_comb begin
      bus.cpu_gnt   = cpu_win;
      bus.vid_gnt   = vid_win;
      bus.ram_cs    = cpu_win || vid_win;
      bus.ram_rw    = reset_n ? (cpu_win ? bus.cpu_rw : 1'b1) : 1'b0;
      bus.ram_addr  = cpu_win ? bus.cpu_addr : (vid_win ? bus.vid_addr : '0);
      bus.ram_wdata = cpu_win ? bus.cpu_wdata : '0;
   end

   // Stage p1: ownership of the read data the RAM returns one cycle after the grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q        <= OWN_VID;
         cpu_wait_q    <= '0;
         cpu_rvalid_p1 <= 1'b0;
         vid_rvalid_p1 <= 1'b0;
      end else begin
         if (cpu_win)      last_q <= OWN_CPU;
         else if (vid_win) last_q <= OWN_VID;
         if (cpu_win || !bus.cpu_req) cpu_wait_q <= '0;
         else if (vid_win)            cpu_wait_q <= wait_sat_inc(cpu_wait_q);
         cpu_rvalid_p1 <= cpu_win && bus.cpu_rw;
         vid_rvalid_p1 <= vid_win;
      end
   end

   assign bus.cpu_rvalid = cpu_rvalid_p1;
   assign bus.vid_rvalid = vid_rvalid_p1;
   assign bus.cpu_rdata  = bus.ram_rdata;
   assign bus.vid_rdata  = bus.ram_rdata;

`ifdef ARB_STATS_EN
   function automatic logic [STAT_W-1:0] stat_sat_inc(input logic [STAT_W-1:0] v);
      if (&v) return v;
      return v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_conflicts <= '0;
         stat_forced    <= '0;
      end else if (stat_clr) begin
         stat_conflicts <= '0;
         stat_forced    <= '0;
      end else begin
         if (bus.cpu_req && bus.vid_req) stat_conflicts <= stat_sat_inc(stat_conflicts);
         if (force_cpu)                  stat_forced    <= stat_sat_inc(stat_forced);
      end
   end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic against a rule-level model.
// Define ARB_STATS_EN for both the RTL and this bench to exercise the statistics counters.
module tb_ram_arbiter;
   localparam int A        = 12;
   localparam int D        = 8;
   localparam int MAX_WAIT = 15;
   localparam int STAT_W   = 16;

   typedef struct packed {
      logic         cg;
      logic         vg;
      logic         cs;
      logic         rw;
      logic [A-1:0] addr;
      logic [D-1:0] wd;
   } bus_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   ram_arbiter_if #(.A(A), .D(D)) bus ();

`ifdef ARB_STATS_EN
   logic              stat_clr;
   logic [STAT_W-1:0] stat_conflicts;
   logic [STAT_W-1:0] stat_forced;
`endif

   ram_arbiter #(.A(A), .D(D), .MAX_WAIT(MAX_WAIT), .STAT_W(STAT_W)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
`ifdef ARB_STATS_EN
      ,
      .stat_clr(stat_clr),
      .stat_conflicts(stat_conflicts),
      .stat_forced(stat_forced)
`endif
   );

   // RAM: synchronous read data, write on cs with rw=0
   logic [D-1:0] mem [0:(1<<A)-1];
   always @(posedge clk) begin
      if (bus.ram_cs) begin
         if (bus.ram_rw) bus.ram_rdata <= mem[bus.ram_addr];
         else            mem[bus.ram_addr] <= bus.ram_wdata;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: 0 none, 1 CPU, 2 video
   int           m_last;
   int           m_wait;
   logic [D-1:0] m_mem   [0:(1<<A)-1];
   bit           m_known [0:(1<<A)-1];
`ifdef ARB_STATS_EN
   int           m_conf;
   int           m_forced;
`endif

   function automatic int model_winner();
      if (!reset_n) return 0;
      if (bus.cpu_req && m_wait == MAX_WAIT) return 1;
      if (bus.vid_urgent) return bus.vid_req ? 2 : (bus.cpu_req ? 1 : 0);
      if (bus.cpu_req && bus.vid_req) return (m_last == 2) ? 1 : 2;
      return bus.cpu_req ? 1 : (bus.vid_req ? 2 : 0);
   endfunction

   task automatic model_reset();
      m_last = 2;
      m_wait = 0;
`ifdef ARB_STATS_EN
      m_conf   = 0;
      m_forced = 0;
`endif
   endtask

   // One clock: sample the combinational bus, predict it, cross the edge, sample the rvalids.
   task automatic run_cycle(output bus_t ob, output bus_t eb, output logic [1:0] orv,
                            output logic [1:0] erv, output logic [D-1:0] ord,
                            output logic [D-1:0] erd, output logic rchk);
      int           win;
      logic         creq, crw;
      logic [A-1:0] caddr;
      logic [D-1:0] cwd;
      #1;
      ob    = {bus.cpu_gnt, bus.vid_gnt, bus.ram_cs, bus.ram_rw, bus.ram_addr, bus.ram_wdata};
      win   = model_winner();
      creq  = bus.cpu_req;
      crw   = bus.cpu_rw;
      caddr = bus.cpu_addr;
      cwd   = bus.cpu_wdata;
      case (win)
         1:       eb = {1'b1, 1'b0, 1'b1, crw, caddr, cwd};
         2:       eb = {1'b0, 1'b1, 1'b1, 1'b1, bus.vid_addr, {D{1'b0}}};
         default: eb = {1'b0, 1'b0, 1'b0, reset_n, {A{1'b0}}, {D{1'b0}}};
      endcase
      erv  = {(win == 1) && crw, win == 2};
      rchk = 1'b0;
      erd  = '0;
      if (win == 1 && crw) begin rchk = m_known[caddr];        erd = m_mem[caddr];        end
      if (win == 2)        begin rchk = m_known[bus.vid_addr]; erd = m_mem[bus.vid_addr]; end
`ifdef ARB_STATS_EN
      if (!reset_n || stat_clr) begin
         m_conf   = 0;
         m_forced = 0;
      end else begin
         if (creq && bus.vid_req && m_conf < (1 << STAT_W) - 1) m_conf++;
         if (creq && m_wait == MAX_WAIT && m_forced < (1 << STAT_W) - 1) m_forced++;
      end
`endif
      @(posedge clk);
      #1;
      orv = {bus.cpu_rvalid, bus.vid_rvalid};
      ord = erv[1] ? bus.cpu_rdata : bus.vid_rdata;
      if (!reset_n) begin
         m_last = 2;
         m_wait = 0;
      end else begin
         if (win != 0) m_last = win;
         if (win == 1 || !creq) m_wait = 0;
         else if (win == 2 && m_wait < MAX_WAIT) m_wait++;
         if (win == 1 && !crw) begin
            m_mem[caddr]   = cwd;
            m_known[caddr] = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.cpu_req    = 1'b0;
      bus.vid_req    = 1'b0;
      bus.vid_urgent = 1'b0;
   endtask

   task automatic do_reset();
      bus_t ob, eb; logic [1:0] orv, erv; logic [D-1:0] ord, erd; logic rchk;
      idle_inputs();
      reset_n = 1'b0;
      run_cycle(ob, eb, orv, erv, ord, erd, rchk);
      reset_n = 1'b1;
   endtask

   task automatic cpu_access(input logic rw, input logic [A-1:0] addr, input logic [D-1:0] wd,
                             output bus_t ob, output bus_t eb, output logic [1:0] orv,
                             output logic [1:0] erv, output logic [D-1:0] ord,
                             output logic [D-1:0] erd, output logic rchk);
      bus.cpu_req   = 1'b1;
      bus.cpu_rw    = rw;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wd;
      bus.vid_req   = 1'b0;
      run_cycle(ob, eb, orv, erv, ord, erd, rchk);
      bus.cpu_req = 1'b0;
   endtask

   task automatic test_reset();
      bus_t ob, eb; logic [1:0] orv, erv; logic [D-1:0] ord, erd; logic rchk;
      reset_n        = 1'b0;
      bus.cpu_req    = 1'b1;
      bus.vid_req    = 1'b1;
      bus.cpu_rw     = 1'b0;
      bus.cpu_addr   = 12'hABC;
      bus.cpu_wdata  = 8'h55;
      bus.vid_addr   = 12'h123;
      for (int i = 0; i < 2; i++) begin
         bus.vid_urgent = 1'($urandom_range(0, 1));
         run_cycle(ob, eb, orv, erv, ord, erd, rchk);
         n_checks++;
         if (ob !== '0) begin n_fail++; $display("FAIL reset_bus got %h expected 0", ob); end
         n_checks++;
         if (orv !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b expected 00", orv); end
      end
      idle_inputs();
      reset_n = 1'b1;
   endtask

   task automatic test_cpu_read();
      bus_t ob, eb; logic [1:0] orv, erv; logic [D-1:0] ord, erd; logic rchk;
      cpu_access(1'b0, 12'h010, 8'hA5, ob, eb, orv, erv, ord, erd, rchk);
      cpu_access(1'b1, 12'h010, 8'h00, ob, eb, orv, erv, ord, erd, rchk);
      n_checks++;
      if (ob !== eb) begin n_fail++; $display("FAIL cpu_read_bus got %h expected %h", ob, eb); end
      n_checks++;
      if (orv !== 2'b10) begin n_fail++; $display("FAIL cpu_read_rvalid got %b expected 10", orv); end
      n_checks++;
      if (ord !== 8'hA5) begin n_fail++; $display("FAIL cpu_read_data got %h expected a5", ord); end
      run_cycle(ob, eb, orv, erv, ord, erd, rchk);
      n_checks++;
      if (orv !== 2'b00) begin n_fail++; $display("FAIL cpu_read_single_pulse got %b expected 00", orv); end
   endtask

   task automatic test_cpu_write();
      bus_t ob, eb; logic [1:0] orv, erv; logic [D-1:0] ord, erd; logic rchk;
      cpu_access(1'b0, 12'h020, 8'h3C, ob, eb, orv, erv, ord, erd, rchk);
      n_checks++;
      if (ob !== eb) begin n_fail++; $display("FAIL cpu_write_bus got %h expected %h", ob, eb); end
      n_checks++;
      if (orv !== 2'b00) begin n_fail++; $display("FAIL cpu_write_no_rvalid got %b expected 00", orv); end
      cpu_access(1'b1, 12'h020, 8'h00, ob, eb, orv, erv, ord, erd, rchk);
      n_checks++;
      if (orv !== 2'b10 || ord !== 8'h3C) begin
         n_fail++; $display("FAIL cpu_write_readback got rv=%b data=%h expected rv=10 data=3c", orv, ord);
      end
   endtask

   task automatic test_rr_tie();
      bus_t ob, eb; logic [1:0] orv, erv; logic [D-1:0] ord, erd; logic rchk;
      logic [1:0] want [4];
      want[0] = 2'b10; want[1] = 2'b01; want[2] = 2'b10; want[3] = 2'b01;
      do_reset();
      bus.cpu_req  = 1'b1;
      bus.cpu_rw   = 1'b1;
      bus.cpu_addr = 12'h010;
      bus.vid_req  = 1'b1;
      bus.vid_addr = 12'h020;
      for (int i = 0; i < 4; i++) begin
         run_cycle(ob, eb, orv, erv, ord, erd, rchk);
         n_checks++;
         if ({ob.cg, ob.vg} !== want[i]) begin
            n_fail++; $display("FAIL rr_tie_gnt[%0d] got %b expected %b", i, {ob.cg, ob.vg}, want[i]);
         end
         n_checks++;
         if (orv !== want[i]) begin
            n_fail++; $display("FAIL rr_tie_rvalid[%0d] got %b expected %b", i, orv, want[i]);
         end
         if (rchk) begin
            n_checks++;
            if (ord !== erd) begin n_fail++; $display("FAIL rr_tie_data[%0d] got %h expected %h", i, ord, erd); end
         end
      end
      idle_inputs();
   endtask

   task automatic test_starvation();
      bus_t ob, eb; logic [1:0] orv, erv; logic [D-1:0] ord, erd; logic rchk;
      do_reset();
      bus.vid_urgent = 1'b1;
      bus.vid_req    = 1'b1;
      bus.vid_addr   = 12'h300;
      bus.cpu_req    = 1'b1;
      bus.cpu_rw     = 1'b1;
      bus.cpu_addr   = 12'h010;
      for (int i = 0; i < 17; i++) begin
         run_cycle(ob, eb, orv, erv, ord, erd, rchk);
         n_checks++;
         if ({ob.cg, ob.vg} !== ((i == 15) ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL starve_gnt[%0d] got %b expected %b", i, {ob.cg, ob.vg},
                               (i == 15) ? 2'b10 : 2'b01);
         end
         if (i >= 14) begin
            n_checks++;
            if (ob !== eb) begin n_fail++; $display("FAIL starve_bus[%0d] got %h expected %h", i, ob, eb); end
         end
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      bus_t ob, eb; logic [1:0] orv, erv; logic [D-1:0] ord, erd; logic rchk;
      bus.vid_req  = 1'b1;
      bus.vid_addr = 12'h020;
      #1;
      n_checks++;
      if (bus.vid_gnt !== 1'b1) begin n_fail++; $display("FAIL areset_pre_gnt got %b expected 1", bus.vid_gnt); end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.vid_gnt, bus.ram_cs} !== 2'b00) begin
         n_fail++; $display("FAIL areset_outputs got gnt/cs=%b expected 00", {bus.vid_gnt, bus.ram_cs});
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.vid_rvalid !== 1'b0) begin n_fail++; $display("FAIL areset_rvalid got %b expected 0", bus.vid_rvalid); end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      bus.cpu_req  = 1'b1;
      bus.cpu_rw   = 1'b1;
      bus.cpu_addr = 12'h010;
      run_cycle(ob, eb, orv, erv, ord, erd, rchk);
      n_checks++;
      if ({ob.cg, ob.vg} !== 2'b10) begin
         n_fail++; $display("FAIL areset_first_tie got %b expected 10", {ob.cg, ob.vg});
      end
      n_checks++;
      if (ob !== eb) begin n_fail++; $display("FAIL areset_first_bus got %h expected %h", ob, eb); end
      idle_inputs();
   endtask

   task automatic test_random();
      bus_t ob, eb; logic [1:0] orv, erv; logic [D-1:0] ord, erd; logic rchk;
      logic c_done, v_done;
      c_done = 1'b1;
      v_done = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (!bus.cpu_req || c_done) begin
            bus.cpu_req   = 1'($urandom_range(0, 1));
            bus.cpu_rw    = 1'($urandom_range(0, 1));
            bus.cpu_addr  = A'(32'h100 + $urandom_range(0, 15));
            bus.cpu_wdata = D'($urandom);
         end else if ($urandom_range(0, 19) == 0) begin
            bus.cpu_req = 1'b0;
         end
         if (!bus.vid_req || v_done) begin
            bus.vid_req  = ($urandom_range(0, 3) != 0);
            bus.vid_addr = A'(32'h100 + $urandom_range(0, 15));
         end else if ($urandom_range(0, 19) == 0) begin
            bus.vid_req = 1'b0;
         end
         bus.vid_urgent = ($urandom_range(0, 3) == 0);
         run_cycle(ob, eb, orv, erv, ord, erd, rchk);
         n_checks++;
         if (ob !== eb) begin n_fail++; $display("FAIL rand_bus[%0d] got %h expected %h", i, ob, eb); end
         n_checks++;
         if (orv !== erv) begin n_fail++; $display("FAIL rand_rvalid[%0d] got %b expected %b", i, orv, erv); end
         if (rchk) begin
            n_checks++;
            if (ord !== erd) begin n_fail++; $display("FAIL rand_data[%0d] got %h expected %h", i, ord, erd); end
         end
         c_done = eb.cg;
         v_done = eb.vg;
      end
      idle_inputs();
      run_cycle(ob, eb, orv, erv, ord, erd, rchk);
   endtask

`ifdef ARB_STATS_EN
   task automatic test_stats();
      bus_t ob, eb; logic [1:0] orv, erv; logic [D-1:0] ord, erd; logic rchk;
      n_checks++;
      if (stat_conflicts !== STAT_W'(m_conf) || stat_forced !== STAT_W'(m_forced)) begin
         n_fail++; $display("FAIL stats_after_random got %0d/%0d expected %0d/%0d",
                            stat_conflicts, stat_forced, m_conf, m_forced);
      end
      idle_inputs();
      stat_clr = 1'b1;
      run_cycle(ob, eb, orv, erv, ord, erd, rchk);
      stat_clr       = 1'b0;
      bus.vid_urgent = 1'b1;
      bus.vid_req    = 1'b1;
      bus.cpu_req    = 1'b1;
      bus.cpu_rw     = 1'b1;
      for (int i = 0; i < 16; i++) run_cycle(ob, eb, orv, erv, ord, erd, rchk);
      n_checks++;
      if (stat_conflicts !== 16'd16 || stat_forced !== 16'd1) begin
         n_fail++; $display("FAIL stats_count got %0d/%0d expected 16/1", stat_conflicts, stat_forced);
      end
      stat_clr = 1'b1;
      run_cycle(ob, eb, orv, erv, ord, erd, rchk);
      stat_clr = 1'b0;
      n_checks++;
      if (stat_conflicts !== '0 || stat_forced !== '0) begin
         n_fail++; $display("FAIL stats_clr got %0d/%0d expected 0/0", stat_conflicts, stat_forced);
      end
      idle_inputs();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n        = 1'b0;
      bus.cpu_req    = 1'b0;
      bus.cpu_rw     = 1'b1;
      bus.cpu_addr   = '0;
      bus.cpu_wdata  = '0;
      bus.vid_req    = 1'b0;
      bus.vid_addr   = '0;
      bus.vid_urgent = 1'b0;
`ifdef ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      for (int i = 0; i < (1 << A); i++) m_known[i] = 1'b0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_cpu_read();
      test_cpu_write();
      test_rr_tie();
      test_starvation();
      test_async_reset();
      test_random();
`ifdef ARB_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
